// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and types for the external memory bus arbiter.
//   - data_type size encodings and the byte length they imply
//   - default I/O-space selector for addr[17:16]
//   - arbiter FSM state encoding
package mem_arbiter_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [1:0] IoSelDefault = 2'b11;

  // Instruction fetches are always whole words.
  localparam logic [2:0] InstLen = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StInstRd,
    StDataRd,
    StDataWr,
    StIoWait
  } state_e;

  // Number of bus bytes for a data_type size field (reserved 11 behaves as a word).
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      SizeByte: len = 3'd1;
      SizeHalf: len = 3'd2;
      SizeWord: len = 3'd4;
      default:  len = 3'd4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_arb_extend.sv
// mem_arb_extend: combinational load-result extension.
// Ports:
//   raw       in  32  assembled little-endian word from the bus
//   data_type in  3   [1:0] size, [2] = 1 selects zero extension
//   res       out 32  sign/zero-extended result (words pass through)
module mem_arb_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  data_type,
  output logic [31:0] res
);

  logic fill_bit;

  always_comb begin
    fill_bit = 1'b0;
    res      = raw;
    case (data_type[1:0])
      SizeByte: begin
        fill_bit = raw[7] & ~data_type[2];
        res      = {{24{fill_bit}}, raw[7:0]};
      end
      SizeHalf: begin
        fill_bit = raw[15] & ~data_type[2];
        res      = {{16{fill_bit}}, raw[15:0]};
      end
      default: res = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole master of the 8-bit external memory bus. Arbitrates the
// instruction-fetch port (word reads) and the load/store port (1/2/4-byte
// reads and writes) and serialises each request one byte per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               global ready; all state freezes while low
//   clear             pipeline flush; aborts reads, never stores
//   inst_*            instruction request (valid/addr) and response (ready/res)
//   data_*            load/store request (valid/wr/type/addr/value), response (ready/res)
//   mem_din/mem_dout  bus read/write byte; mem_din answers the previous cycle's mem_a
//   mem_a/mem_wr      bus address and write strobe
//   io_buffer_full    UART tx buffer full; stalls I/O writes in IO_WAIT
//
// Build option: define MEM_ARB_PERF_EN to add perf_inst_cnt, perf_data_cnt and
// perf_stall_cnt (completed fetches, completed data requests, stall cycles).
//
// Timing: cycle 0 is the accept cycle and drives the first address
// combinationally. In read cycle k the byte for address k-1 is on mem_din; the
// final byte is merged combinationally so ready and the result appear in cycle n.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [1:0]  IO_SEL       = IoSelDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        clear,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        data_valid,
  input  logic        data_wr,
  input  logic [2:0]  data_type,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_value,
  output logic        data_ready,
  output logic [31:0] data_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_data_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  input  logic        io_buffer_full
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         len_q, len_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         dtype_q, dtype_d;
  logic [31:0]        inst_res_q, data_res_q;

  logic        grant_inst, grant_data;
  logic        accept_inst, accept_data;
  logic        is_io;
  logic [31:0] asm_word;
  logic [7:0]  wr_byte;
  logic [31:0] ext_res;

  mem_arb_extend u_extend (
    .raw       (asm_word),
    .data_type (dtype_q),
    .res       (ext_res)
  );

  // Collected bytes with the byte currently on mem_din merged at position cnt-1.
  always_comb begin
    asm_word = buf_q;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q == 3'(i + 1)) asm_word[i*8 +: 8] = mem_din;
    end
  end

  always_comb begin
    wr_byte = wdata_q[7:0];
    for (int i = 1; i < 4; i++) begin
      if (cnt_q == 3'(i)) wr_byte = wdata_q[i*8 +: 8];
    end
  end

  assign is_io = (data_addr[17:16] == IO_SEL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    starve_d    = starve_q;
    base_d      = base_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    dtype_d     = dtype_q;
    mem_a       = 32'd0;
    mem_dout    = 8'd0;
    mem_wr      = 1'b0;
    inst_ready  = 1'b0;
    data_ready  = 1'b0;
    grant_inst  = 1'b0;
    grant_data  = 1'b0;
    accept_inst = 1'b0;
    accept_data = 1'b0;

    if (!rdy) begin
      // Keep presenting the last read address so mem_din still carries the
      // byte the resumed cycle expects. Writes and idle keep the bus quiet.
      if (state_q == StInstRd || state_q == StDataRd) begin
        mem_a = base_q + 32'(cnt_q) - 32'd1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (inst_valid && starve_q == StarveW'(STARVE_LIMIT)) grant_inst = 1'b1;
          else if (data_valid)                                   grant_data = 1'b1;
          else if (inst_valid)                                   grant_inst = 1'b1;

          // A flush cancels a read accept but never a store.
          accept_data = grant_data && (data_wr || !clear);
          accept_inst = grant_inst && !clear;

          if (accept_data) begin
            base_d  = data_addr;
            wdata_d = data_value;
            dtype_d = data_type;
            cnt_d   = 3'd1;
            if (data_wr) begin
              if (is_io) begin
                // UART writes (including the 0x30004 stop write) are one byte.
                len_d = 3'd1;
                if (io_buffer_full) begin
                  state_d = StIoWait;
                  cnt_d   = 3'd0;
                end else begin
                  state_d  = StDataWr;
                  mem_a    = data_addr;
                  mem_dout = data_value[7:0];
                  mem_wr   = 1'b1;
                end
              end else begin
                len_d    = size_to_len(data_type[1:0]);
                state_d  = StDataWr;
                mem_a    = data_addr;
                mem_dout = data_value[7:0];
                mem_wr   = 1'b1;
              end
            end else begin
              len_d   = size_to_len(data_type[1:0]);
              state_d = StDataRd;
              mem_a   = data_addr;
            end
          end else if (accept_inst) begin
            base_d  = inst_addr;
            len_d   = InstLen;
            cnt_d   = 3'd1;
            state_d = StInstRd;
            mem_a   = inst_addr;
          end

          if (!inst_valid || accept_inst) begin
            starve_d = '0;
          end else if (accept_data) begin
            starve_d = starve_q + StarveW'(1);
          end
        end

        StInstRd, StDataRd: begin
          if (clear) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else begin
            buf_d = asm_word;
            if (cnt_q == len_q) begin
              inst_ready = (state_q == StInstRd);
              data_ready = (state_q == StDataRd);
              state_d    = StIdle;
              cnt_d      = 3'd0;
            end else begin
              mem_a = base_q + 32'(cnt_q);
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        StDataWr: begin
          if (cnt_q == len_q) begin
            data_ready = 1'b1;
            state_d    = StIdle;
            cnt_d      = 3'd0;
          end else begin
            mem_a    = base_q + 32'(cnt_q);
            mem_dout = wr_byte;
            mem_wr   = 1'b1;
            cnt_d    = cnt_q + 3'd1;
          end
        end

        StIoWait: begin
          if (!io_buffer_full) begin
            mem_a    = base_q;
            mem_dout = wdata_q[7:0];
            mem_wr   = 1'b1;
            cnt_d    = 3'd1;
            state_d  = StDataWr;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign inst_res = inst_ready ? asm_word : inst_res_q;
  assign data_res = (data_ready && state_q == StDataRd) ? ext_res : data_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      starve_q   <= '0;
      base_q     <= 32'd0;
      buf_q      <= 32'd0;
      wdata_q    <= 32'd0;
      dtype_q    <= 3'd0;
      inst_res_q <= 32'd0;
      data_res_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      starve_q   <= starve_d;
      base_q     <= base_d;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      dtype_q    <= dtype_d;
      inst_res_q <= inst_res;
      data_res_q <= data_res;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic stall_evt;

  // The fetch port is waiting whenever it is valid and the bus serves data.
  assign stall_evt = (state_q == StIoWait) ||
                     (inst_valid && (accept_data || state_q == StDataRd ||
                                     state_q == StDataWr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_cnt  <= 32'd0;
      perf_data_cnt  <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else if (rdy) begin
      if (inst_ready) perf_inst_cnt  <= perf_inst_cnt + 32'd1;
      if (data_ready) perf_data_cnt  <= perf_data_cnt + 32'd1;
      if (stall_evt)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clear;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid, data_wr;
  logic [2:0]  data_type;
  logic [31:0] data_addr, data_value;
  logic        data_ready;
  logic [31:0] data_res;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_stall_cnt;
`endif

  mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .clear          (clear),
    .inst_valid     (inst_valid),
    .inst_addr      (inst_addr),
    .inst_ready     (inst_ready),
    .inst_res       (inst_res),
    .data_valid     (data_valid),
    .data_wr        (data_wr),
    .data_type      (data_type),
    .data_addr      (data_addr),
    .data_value     (data_value),
    .data_ready     (data_ready),
    .data_res       (data_res),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
`ifdef MEM_ARB_PERF_EN
    .perf_inst_cnt  (perf_inst_cnt),
    .perf_data_cnt  (perf_data_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_inst;
    logic [31:0] val;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;

  resp_t exp_q[$];
  wr_t   exp_w[$];
  logic [31:0] last_dres = 32'd0;

  // Byte memory: answers the address seen in the previous cycle.
  logic [7:0] mem [logic [31:0]];

  always @(posedge clk) begin
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
    if (mem_wr) mem[mem_a] = mem_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_ready || data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected ready", 32'(inst_ready) | 32'(data_ready), 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("ready port is inst", 32'(inst_ready), 32'(e.is_inst));
          chk("ready exclusive", 32'(inst_ready & data_ready), 32'd0);
          chk(e.is_inst ? "inst_res" : "data_res", e.is_inst ? inst_res : data_res, e.val);
          if (e.cyc >= 0) chk("ready cycle", cyc, e.cyc);
        end
      end
      if (mem_wr) begin
        if (exp_w.size() == 0) begin
          chk("unexpected write", mem_a, 32'hxxxx_xxxx);
        end else begin
          wr_t w;
          w = exp_w.pop_front();
          chk("write addr", mem_a, w.a);
          chk("write data", 32'(mem_dout), 32'(w.d));
          chk("write cycle", cyc, w.cyc);
        end
      end
      if (!rdy) chk("frozen ready/wr", 32'(inst_ready | data_ready | mem_wr), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit inst);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (inst ? inst_ready : data_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL ready timeout: got no pulse, expected %s ready", inst ? "inst" : "data");
  endtask

  // Issue a data request at the current cycle; lat is the expected ready offset.
  task automatic do_data(input bit wr, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] v, input logic [31:0] ev, input int lat);
    data_wr    = wr;
    data_type  = ty;
    data_addr  = a;
    data_value = v;
    data_valid = 1'b1;
    exp_q.push_back('{1'b0, wr ? last_dres : ev, (lat < 0) ? -1 : cyc + lat});
    if (!wr) last_dres = ev;
    wait_ready(1'b0);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_inst(input logic [31:0] a, input logic [31:0] ev, input int lat);
    inst_addr  = a;
    inst_valid = 1'b1;
    exp_q.push_back('{1'b1, ev, (lat < 0) ? -1 : cyc + lat});
    wait_ready(1'b1);
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    exp_w.push_back('{a, d, c});
  endtask

  initial begin
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h104] = 8'h55; mem[32'h105] = 8'h66; mem[32'h106] = 8'h77; mem[32'h107] = 8'h88;
    mem[32'h200] = 8'h80;
    mem[32'h210] = 8'h34; mem[32'h211] = 8'h92;

    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    inst_valid = 1'b0; inst_addr = 32'd0;
    data_valid = 1'b0; data_wr = 1'b0; data_type = 3'd0; data_addr = 32'd0; data_value = 32'd0;

    repeat (2) @(negedge clk);
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_dout", 32'(mem_dout), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset inst_ready", 32'(inst_ready), 32'd0);
    chk("reset data_ready", 32'(data_ready), 32'd0);
    chk("reset inst_res", inst_res, 32'd0);
    chk("reset data_res", data_res, 32'd0);
    rst_n = 1'b1;
    tick();

    // Word load: addresses 0x100..0x103, ready 4 cycles after accept.
    fork
      do_data(1'b0, 3'b010, 32'h100, 32'd0, 32'h4433_2211, 4);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("LW mem_a", mem_a, 32'h100 + 32'(k));
        chk("LW mem_wr", 32'(mem_wr), 32'd0);
      end
    join

    // Byte/half extension.
    do_data(1'b0, 3'b000, 32'h200, 32'd0, 32'hFFFF_FF80, 1);
    do_data(1'b0, 3'b100, 32'h200, 32'd0, 32'h0000_0080, 1);
    do_data(1'b0, 3'b001, 32'h210, 32'd0, 32'hFFFF_9234, 2);
    do_data(1'b0, 3'b101, 32'h210, 32'd0, 32'h0000_9234, 2);

    // Word store with a flush in its second cycle: all four bytes still go out.
    push_wr(32'h300, 8'hD4, cyc);
    push_wr(32'h301, 8'hC3, cyc + 1);
    push_wr(32'h302, 8'hB2, cyc + 2);
    push_wr(32'h303, 8'hA1, cyc + 3);
    fork
      do_data(1'b1, 3'b010, 32'h300, 32'hA1B2_C3D4, 32'd0, 4);
      begin tick(); clear = 1'b1; tick(); clear = 1'b0; end
    join
    do_data(1'b0, 3'b010, 32'h300, 32'd0, 32'hA1B2_C3D4, 4);

    // Half store.
    push_wr(32'h310, 8'hEF, cyc);
    push_wr(32'h311, 8'hBE, cyc + 1);
    do_data(1'b1, 3'b001, 32'h310, 32'h1234_BEEF, 32'd0, 2);

    // UART write held off by a full buffer for three cycles.
    io_buffer_full = 1'b1;
    push_wr(32'h3_0000, 8'h41, cyc + 3);
    fork
      do_data(1'b1, 3'b000, 32'h3_0000, 32'h0000_0041, 32'd0, 4);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("IO wait mem_wr", 32'(mem_wr), 32'd0);
          chk("IO wait mem_a", mem_a, 32'd0);
        end
        tick();
        io_buffer_full = 1'b0;
      end
    join

    // Stop address: a word store becomes a single byte.
    push_wr(32'h3_0004, 8'h78, cyc);
    do_data(1'b1, 3'b010, 32'h3_0004, 32'h1234_5678, 32'd0, 1);

    // Flush in the accept cycle: store proceeds, load is deferred one cycle.
    push_wr(32'h320, 8'h5A, cyc);
    fork
      do_data(1'b1, 3'b000, 32'h320, 32'h0000_005A, 32'd0, 1);
      begin clear = 1'b1; tick(); clear = 1'b0; end
    join
    fork
      do_data(1'b0, 3'b000, 32'h320, 32'd0, 32'h0000_005A, 2);
      begin
        clear = 1'b1;
        @(negedge clk);
        chk("cancelled accept mem_a", mem_a, 32'd0);
        tick();
        clear = 1'b0;
      end
    join

    // Fetch aborted by a flush in its cycle 2: no inst_ready, bus idle after.
    inst_addr  = 32'h100;
    inst_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("abort fetch mem_a", mem_a, 32'h101);
    tick();
    clear = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    chk("abort inst_ready", 32'(inst_ready), 32'd0);
    tick();
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after abort mem_a", mem_a, 32'd0);
      chk("after abort inst_ready", 32'(inst_ready), 32'd0);
    end
    tick();
    do_inst(32'h100, 32'h4433_2211, 4);

    // rdy low for five cycles mid-fetch: latency grows by exactly five.
    fork
      do_inst(32'h104, 32'h8877_6655, 9);
      begin
        tick();
        tick();
        rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("frozen mem_a", mem_a, 32'h105);
        end
        tick();
        rdy = 1'b1;
      end
    join

    // Starvation: both ports held; expected grant order D D D D I D D D D I.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) exp_q.push_back('{1'b1, 32'h4433_2211, -1});
      else                  exp_q.push_back('{1'b0, 32'h0000_0011, -1});
    end
    last_dres = 32'h0000_0011;
    data_wr = 1'b0; data_type = 3'b000; data_addr = 32'h100;
    inst_addr = 32'h100;
    fork
      begin
        data_valid = 1'b1;
        repeat (8) begin wait_ready(1'b0); tick(); end
        data_valid = 1'b0;
      end
      begin
        inst_valid = 1'b1;
        repeat (2) begin wait_ready(1'b1); tick(); end
        inst_valid = 1'b0;
      end
    join

    repeat (3) tick();
    chk("responses outstanding", 32'(exp_q.size()), 32'd0);
    chk("writes outstanding", 32'(exp_w.size()), 32'd0);

    // Asynchronous reset mid-cycle clears held results immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset data_res", data_res, 32'd0);
    chk("async reset inst_res", inst_res, 32'd0);
    chk("async reset mem_a", mem_a, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
